// File: rtl/mul_booth_seq_if.sv
// Request/response bundle for the sequential Booth multiplier: operands and
// mode in from the control unit, busy/done status and the HI/LO product out.
interface mul_booth_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  sign_md;
   logic [DATA_WIDTH-1:0] Q;
   logic [DATA_WIDTH-1:0] M;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] HI;
   logic [DATA_WIDTH-1:0] LO;

   modport master (output start, sign_md, Q, M, input busy, done, HI, LO);
   modport slave  (input start, sign_md, Q, M, output busy, done, HI, LO);
endinterface

// File: rtl/mul_booth_seq.sv
// Multi-cycle radix-4 Booth multiplier: one Booth digit retired per clock.
// Optional macro MUL_EARLY_TERM_EN finishes as soon as every remaining digit is zero.
module mul_booth_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH/2+2)
) (
   input logic          clock,
   input logic          clear,
   mul_booth_seq_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int N  = W/2 + 1;
   localparam int AW = 2*W + 2;
   localparam int MW = W + 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_WIDTH-1:0] LAST_DIGIT = CNT_WIDTH'(N-1);

   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [AW-1:0]        acc;
   logic [AW-1:0]        q_sh;
   logic [MW-1:0]        m_sh;
   logic [AW-1:0]        partial;
   logic [AW-1:0]        acc_next;
   logic [MW-1:0]        m_next;
   logic [W-1:0]         hi;
   logic [W-1:0]         lo;
   logic                 q_sx;
   logic                 m_sx;
   logic                 finish;

   assign q_sx = bus.sign_md & bus.Q[W-1];
   assign m_sx = bus.sign_md & bus.M[W-1];

   // q_sh holds Q_ext << 2i and m_sh[2:0] holds the current Booth triple.
   always_comb begin
      partial = '0;  // NOTE: default assignment first, so no path leaves partial unassigned (no latch)
      case (m_sh[2:0])
         3'b001, 3'b010: partial = q_sh;
         3'b011:         partial = q_sh << 1;
         3'b100:         partial = -(q_sh << 1);
         3'b101, 3'b110: partial = -q_sh;
         default:        partial = '0;
      endcase
   end

   assign acc_next = acc + partial;
   assign m_next   = {{2{m_sh[MW-1]}}, m_sh[MW-1:2]};

`ifdef MUL_EARLY_TERM_EN
   // m_next[0] is the last processed bit; all-equal means every remaining digit is zero.
   assign finish = (cnt == LAST_DIGIT) || (m_next == '0) || (&m_next);
`else
   assign finish = (cnt == LAST_DIGIT);
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;  // NOTE: non-blocking for all sequential state, so every register sees pre-edge values
         cnt   <= '0;
         acc   <= '0;
         q_sh  <= '0;
         m_sh  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  q_sh  <= {{(W+2){q_sx}}, bus.Q};
                  m_sh  <= {{2{m_sx}}, bus.M, 1'b0};
                  acc   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc  <= acc_next;
               q_sh <= q_sh << 2;
               m_sh <= m_next;
               cnt  <= cnt + 1'b1;
               if (finish) begin
                  hi    <= acc_next[2*W-1:W];
                  lo    <= acc_next[W-1:0];
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.HI   = hi;
   assign bus.LO   = lo;
endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: reference product model, scoreboard
// queue of expected products, latency and HI/LO-hold checks per operation.
module tb_mul_booth_seq;
   localparam int W   = 32;
   localparam int N   = W/2 + 1;
   localparam int BUDGET = 40;
`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clock = 1'b0;
   logic clear = 1'b1;
   always #5 clock = ~clock;

   mul_booth_seq_if #(.DATA_WIDTH(W)) bus ();
   mul_booth_seq #(.DATA_WIDTH(W)) dut (.clock(clock), .clear(clear), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] sb_q[$];
   logic [W-1:0]   last_hi = '0;
   logic [W-1:0]   last_lo = '0;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] q, input logic [W-1:0] m,
                                            input logic sgn);
      logic [2*W-1:0] a;
      logic [2*W-1:0] b;
      a = sgn ? {{W{q[W-1]}}, q} : {{W{1'b0}}, q};
      b = sgn ? {{W{m[W-1]}}, m} : {{W{1'b0}}, m};
      return a * b;
   endfunction

   // Edges from start capture until DONE is entered.
   function automatic int exp_edges(input logic [W-1:0] m, input logic sgn);
      logic [W+1:0] me;
      logic         same;
      if (!EARLY) return N;
      me = {{2{sgn & m[W-1]}}, m};
      for (int i = 1; i < N; i++) begin
         same = 1'b1;
         for (int j = 2*i; j <= W+1; j++)
            if (me[j] !== me[2*i-1]) same = 1'b0;
         if (same) return i;
      end
      return N;
   endfunction

   task automatic check_idle(input string name);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== last_hi || bus.LO !== last_lo) begin
         errors++;
         $display("FAIL %s idle: busy=%b done=%b HI=%h LO=%h, expected busy=0 done=0 HI=%h LO=%h",
                  name, bus.busy, bus.done, bus.HI, bus.LO, last_hi, last_lo);
      end
   endtask

   task automatic check_result(input string name, input int k, input int want);
      logic [2*W-1:0] exp;
      checks++;
      if (k !== want) begin
         errors++;
         $display("FAIL %s latency: done after edge %0d, expected edge %0d", name, k, want);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_in_done: busy=%b, expected 1", name, bus.busy);
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: done with empty queue", name);
      end else begin
         exp = sb_q.pop_front();
         if ({bus.HI, bus.LO} !== exp) begin
            errors++;
            $display("FAIL %s product: HI=%h LO=%h, expected HI=%h LO=%h",
                     name, bus.HI, bus.LO, exp[2*W-1:W], exp[W-1:0]);
         end
         last_hi = exp[2*W-1:W];
         last_lo = exp[W-1:0];
      end
   endtask

   // Called at a negedge after edge k; checks running status and held HI/LO.
   task automatic check_running(input string name, input int k);
      checks++;
      if (bus.busy !== 1'b1 || bus.HI !== last_hi || bus.LO !== last_lo) begin
         errors++;
         $display("FAIL %s run k=%0d: busy=%b HI=%h LO=%h, expected busy=1 HI=%h LO=%h",
                  name, k, bus.busy, bus.HI, bus.LO, last_hi, last_lo);
      end
   endtask

   task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] m, input logic sgn,
                         input string name);
      int k;
      int want;
      sb_q.push_back(model(q, m, sgn));
      want = exp_edges(m, sgn);
      bus.start = 1'b1; bus.Q = q; bus.M = m; bus.sign_md = sgn;
      @(negedge clock);
      bus.start = 1'b0; bus.Q = $urandom; bus.M = $urandom; bus.sign_md = 1'($urandom_range(0, 1));
      k = 0;
      while (bus.done !== 1'b1 && k < BUDGET) begin
         check_running(name, k);
         k++;
         @(negedge clock);
      end
      if (k >= BUDGET) begin
         checks++; errors++;
         $display("FAIL %s timeout: no done within %0d cycles", name, BUDGET);
         void'(sb_q.pop_back());
         return;
      end
      check_result(name, k, want);
      @(negedge clock);
      check_idle(name);
   endtask

   task automatic test_reset();
      bus.start = 1'b1; bus.Q = 32'h1111_1111; bus.M = 32'h2222_2222; bus.sign_md = 1'b1;
      clear = 1'b1;
      repeat (2) @(negedge clock);
      last_hi = '0; last_lo = '0;
      check_idle("reset");
      bus.start = 1'b0;
      clear = 1'b0;
      @(negedge clock);
      check_idle("reset_release");
   endtask

   task automatic test_basic();
      run_op(32'd3, 32'd5, 1'b1, "basic_3x5");
      checks++;
      if (last_lo !== 32'h0000_000F || last_hi !== 32'h0) begin
         errors++;
         $display("FAIL basic_const: HI=%h LO=%h, expected HI=00000000 LO=0000000f", last_hi, last_lo);
      end
   endtask

   task automatic test_signed();
      run_op(32'hFFFF_FFFD, 32'd5, 1'b1, "signed_m3x5");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "signed_minxmin");
   endtask

   task automatic test_all_ones();
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones_signed");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ones_unsigned");
   endtask

   task automatic test_back_to_back();
      int k;
      int want;
      int hold_at;
      int extra_done;
      sb_q.push_back(model(32'd7, 32'd9, 1'b1));
      want = exp_edges(32'd9, 1'b1);
      hold_at = (want > 5) ? 5 : 1;
      bus.start = 1'b1; bus.Q = 32'd7; bus.M = 32'd9; bus.sign_md = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      k = 0;
      while (bus.done !== 1'b1 && k < BUDGET) begin
         check_running("ignore_start", k);
         if (k == hold_at) begin
            bus.start = 1'b1; bus.Q = 32'd2; bus.M = 32'd2;
         end
         k++;
         @(negedge clock);
      end
      bus.start = 1'b0;
      if (k >= BUDGET) begin
         checks++; errors++;
         $display("FAIL ignore_start timeout: no done within %0d cycles", BUDGET);
         void'(sb_q.pop_back());
         return;
      end
      check_result("ignore_start", k, want);
      extra_done = 0;
      repeat (25) begin
         @(negedge clock);
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin
         errors++;
         $display("FAIL ignore_start second_op: %0d busy/done cycles, expected 0", extra_done);
      end
      check_idle("ignore_start_after");
   endtask

   task automatic test_clear_abort();
      int seen;
      run_op(32'd6, 32'd7, 1'b1, "pre_abort");
      bus.start = 1'b1; bus.Q = 32'd5; bus.M = 32'h7654_3211; bus.sign_md = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      seen = 0;
      repeat (8) begin
         if (bus.done === 1'b1) seen++;
         @(negedge clock);
      end
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      last_hi = '0; last_lo = '0;
      check_idle("abort_clear");
      repeat (25) begin
         @(negedge clock);
         if (bus.done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: %0d done pulses, expected 0", seen);
      end
      run_op(32'd2, 32'd3, 1'b1, "after_abort");
   endtask

   task automatic test_early_term();
      run_op(32'h0000_1234, 32'd0, 1'b1, "early_m0");
      run_op(32'd1234, 32'd3, 1'b1, "early_m3");
      run_op(32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1, "early_neg");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++)
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
   endtask

   initial begin
      bus.start = 1'b0; bus.Q = '0; bus.M = '0; bus.sign_md = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_all_ones();
      test_back_to_back();
      test_clear_abort();
      test_early_term();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
